alu_seq_core: RTL and testbench
===============================

ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 SHALL have parameter W, default 16, operand width in bits (even, W >= 8).
REQ-002 SHALL have parameter SHW, default $clog2(W), shift-amount width taken from a[SHW-1:0].
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port op  input  6  opcode.
REQ-008 SHALL have ports a, b  input  W  operands.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  2W  registered result.
REQ-012 SHALL have port err  output  1  divide-by-zero or illegal opcode, qualified by out_valid.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid and in_ready are both high.
REQ-015 SHALL decode op as follows: 000000 MOV (b), 000100 ADD (b+a), 000101 SUB (b-a), 000110 NEG (-a), 000111 MUL (a*b, full 2W), 001000 DIV, 001001 OR, 001010 XOR, 001011 NAND, 001100 NOR, 001101 XNOR, 001110 NOT (~a), 001111 LLSH (b<<a[SHW-1:0]), 010000 LRSH (logical b>>a[SHW-1:0]).
REQ-016 SHALL zero-extend every non-MUL, non-DIV result to 2W, wrap ADD/SUB/NEG modulo 2^W, and treat operands as unsigned.
REQ-017 SHALL use the FSM states IDLE, DIV, DONE.
REQ-018 SHALL take IDLE->DONE on accept of any non-DIV op (latency 1: out_valid on the next cycle).
REQ-019 SHALL take IDLE->DIV on accept of DIV with a!=0, and DIV->DONE after exactly W iteration cycles (out_valid W+1 cycles after accept).
REQ-020 SHALL produce for DIV result = {remainder, quotient} of b / a, restoring algorithm, one quotient bit per cycle.
REQ-021 SHALL, for DIV with a==0, go IDLE->DONE with result = {b, all-ones}, err=1, latency 1.
REQ-022 SHALL, for an unlisted op, go IDLE->DONE with result=0, err=1, latency 1.
REQ-023 SHALL hold result and err stable in DONE while out_valid && !out_ready.
REQ-024 SHALL, in DONE with out_ready high, drop out_valid unless a new request is accepted in the same cycle.
REQ-025 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), giving back-to-back throughput of 1 op/cycle for non-DIV ops.
REQ-026 SHALL keep in_ready low throughout DIV and ignore in_valid, op, a and b there.
REQ-027 SHALL sample operands only at accept, so input changes after accept do not affect the result.

Reset
REQ-028 SHALL, while rst_n is low, force state=IDLE, out_valid=0, result=0, err=0, busy=0, in_ready=0, and clear divider registers.
REQ-029 SHALL abort an in-flight DIV or a pending DONE result on reset with no output, and assert in_ready the first cycle after release.

Configuration
REQ-030 SHALL, with ALU_SEQ_DIV_EN defined, implement DIV as REQ-019..021.
REQ-031 SHALL, without ALU_SEQ_DIV_EN, remove the divider and the DIV state, treat op 001000 as illegal (REQ-022), and leave all other behaviour unchanged.

Structure
REQ-032 SHALL place the opcode localparams and the FSM state typedef in shared package alu_seq_pkg.
REQ-033 SHALL implement the iterative divider as sub-module alu_div_iter (start, a, b -> done, quotient, remainder), instantiated only under ALU_SEQ_DIV_EN.

Verification (W=16)
REQ-034 SHALL test: ADD a=0x0001, b=0xFFFF, out_ready=1 -> next cycle out_valid=1, result=0x00000000, err=0.
REQ-035 SHALL test: MUL a=0xFFFF, b=0xFFFF -> result=0xFFFE0001 after 1 cycle.
REQ-036 SHALL test: DIV a=0x0007, b=0x0064 -> out_valid 17 cycles after accept, result={0x0002,0x000E}, in_ready=0 throughout DIV.
REQ-037 SHALL test: DIV a=0 and op=0x3F -> err=1 with results {b,0xFFFF} and 0 respectively.
REQ-038 SHALL test: LRSH a=0x0014, b=0x8000 -> result=0x00000800 (shift by 4), held for 3 cycles with out_ready=0, then back-to-back ADD accepted the cycle out_ready rises.
REQ-039 SHALL test: rst_n low 5 cycles into a DIV -> out_valid never rises for it, in_ready=1 the cycle after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for alu_seq_core.
// Define ALU_SEQ_DIV_EN to include the iterative divide state.
package alu_seq_pkg;

   localparam logic [5:0] OP_MOV  = 6'b000000;
   localparam logic [5:0] OP_ADD  = 6'b000100;
   localparam logic [5:0] OP_SUB  = 6'b000101;
   localparam logic [5:0] OP_NEG  = 6'b000110;
   localparam logic [5:0] OP_MUL  = 6'b000111;
   localparam logic [5:0] OP_DIV  = 6'b001000;
   localparam logic [5:0] OP_OR   = 6'b001001;
   localparam logic [5:0] OP_XOR  = 6'b001010;
   localparam logic [5:0] OP_NAND = 6'b001011;
   localparam logic [5:0] OP_NOR  = 6'b001100;
   localparam logic [5:0] OP_XNOR = 6'b001101;
   localparam logic [5:0] OP_NOT  = 6'b001110;
   localparam logic [5:0] OP_LLSH = 6'b001111;
   localparam logic [5:0] OP_LRSH = 6'b010000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
`ifdef ALU_SEQ_DIV_EN
      ST_DIV  = 2'd2,
`endif
      ST_DONE = 2'd1
   } state_e;

endpackage

// File: rtl/alu_seq_core_div.sv
// Restoring divider producing one quotient bit per cycle; W cycles after start.
// Instantiated by alu_seq_core only when ALU_SEQ_DIV_EN is defined.
module alu_div_iter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);
   import alu_seq_pkg::*;

   localparam int CW = $clog2(W);

   logic [W-1:0]  rem_r;
   logic [W-1:0]  quo_r;
   logic [W-1:0]  div_r;
   logic [CW-1:0] cnt_r;
   logic          active_r;
   logic [W:0]    shifted_s;
   logic [W:0]    trial_s;
   logic          qbit_s;
   logic [W-1:0]  rem_next_s;

   // One restoring step: outputs are the values after the current iteration.
   always_comb begin
      shifted_s  = {rem_r, quo_r[W-1]};
      trial_s    = shifted_s - {1'b0, div_r};
      qbit_s     = 1'b0;
      rem_next_s = shifted_s[W-1:0];
      if (trial_s[W] == 1'b0) begin
         qbit_s     = 1'b1;
         rem_next_s = trial_s[W-1:0];
      end else begin
         qbit_s     = 1'b0;
         rem_next_s = shifted_s[W-1:0];
      end
   end

   assign quotient  = {quo_r[W-2:0], qbit_s};
   assign remainder = rem_next_s;
   assign done      = active_r && (cnt_r == CW'(W - 1));

   // Divider state: dividend shifts out of quo_r as quotient bits shift in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_r    <= {W{1'b0}};
         quo_r    <= {W{1'b0}};
         div_r    <= {W{1'b0}};
         cnt_r    <= {CW{1'b0}};
         active_r <= 1'b0;
      end else if (start) begin
         rem_r    <= {W{1'b0}};
         quo_r    <= b;
         div_r    <= a;
         cnt_r    <= {CW{1'b0}};
         active_r <= 1'b1;
      end else if (active_r) begin
         rem_r <= rem_next_s;
         quo_r <= quotient;
         cnt_r <= cnt_r + CW'(1);
         if (cnt_r == CW'(W - 1)) begin
            active_r <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU with valid/ready handshake and registered 2W-bit result.
// Define ALU_SEQ_DIV_EN to enable the multi-cycle DIV opcode.
module alu_seq_core #(
   parameter int W   = 16,
   parameter int SHW = $clog2(W)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [5:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] result,
   output logic           err,
   output logic           busy
);
   import alu_seq_pkg::*;

   state_e         state_r;
   state_e         state_s;
   logic [2*W-1:0] result_r;
   logic [2*W-1:0] result_s;
   logic           err_r;
   logic           err_s;
   logic           accept_s;

   function automatic logic [W-1:0] alu_w(input logic [5:0] opc,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      logic [W-1:0] r;
      case (opc)
         OP_MOV:  r = y;
         OP_ADD:  r = y + x;
         OP_SUB:  r = y - x;
         OP_NEG:  r = {W{1'b0}} - x;
         OP_OR:   r = y | x;
         OP_XOR:  r = y ^ x;
         OP_NAND: r = ~(y & x);
         OP_NOR:  r = ~(y | x);
         OP_XNOR: r = ~(y ^ x);
         OP_NOT:  r = ~x;
         OP_LLSH: r = y << x[SHW-1:0];
         OP_LRSH: r = y >> x[SHW-1:0];
         default: r = {W{1'b0}};
      endcase
      return r;
   endfunction

   assign in_ready  = rst_n && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready));
   assign accept_s  = in_valid && in_ready;
   assign out_valid = (state_r == ST_DONE);
   assign busy      = (state_r != ST_IDLE);
   assign result    = result_r;
   assign err       = err_r;

`ifdef ALU_SEQ_DIV_EN
   logic         div_start_s;
   logic         div_done_s;
   logic [W-1:0] div_quo_s;
   logic [W-1:0] div_rem_s;

   alu_div_iter #(.W(W)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start_s),
      .a         (a),
      .b         (b),
      .done      (div_done_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );
`endif

   // Next-state and result selection; result/err only change on a load.
   always_comb begin
      state_s  = state_r;
      result_s = result_r;
      err_s    = err_r;
`ifdef ALU_SEQ_DIV_EN
      div_start_s = 1'b0;
`endif
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               state_s  = ST_DONE;
               err_s    = 1'b0;
               result_s = {{W{1'b0}}, alu_w(op, a, b)};
               case (op)
                  OP_MUL: result_s = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                  OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                     if (a == {W{1'b0}}) begin
                        result_s = {b, {W{1'b1}}};
                        err_s    = 1'b1;
                     end else begin
                        state_s     = ST_DIV;
                        div_start_s = 1'b1;
                     end
`else
                     result_s = {2*W{1'b0}};
                     err_s    = 1'b1;
`endif
                  end
                  OP_MOV, OP_ADD, OP_SUB, OP_NEG, OP_OR, OP_XOR, OP_NAND,
                  OP_NOR, OP_XNOR, OP_NOT, OP_LLSH, OP_LRSH: err_s = 1'b0;
                  default: begin
                     result_s = {2*W{1'b0}};
                     err_s    = 1'b1;
                  end
               endcase
            end else if ((state_r == ST_DONE) && out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = state_r;
            end
         end
`ifdef ALU_SEQ_DIV_EN
         ST_DIV: begin
            if (div_done_s) begin
               state_s  = ST_DONE;
               result_s = {div_rem_s, div_quo_s};
               err_s    = 1'b0;
            end else begin
               state_s = ST_DIV;
            end
         end
`endif
         default: state_s = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         result_r <= {2*W{1'b0}};
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         result_r <= result_s;
         err_r    <= err_s;
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (W=16): directed cases plus random traffic
// against a behavioural model; DIV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq_core;
   localparam int W = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [5:0]  op = 6'h00;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic        in_ready;
   logic        out_valid;
   logic        err;
   logic        busy;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   // model: result visible, expected value, pending division countdown
   bit          m_valid = 1'b0;
   logic [31:0] m_res = 32'h0;
   bit          m_err = 1'b0;
   int          busy_cnt = 0;
   logic [31:0] m_pend = 32'h0;

   alu_seq_core #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_long_div(input logic [5:0] o, input logic [15:0] x);
`ifdef ALU_SEQ_DIV_EN
      return (o == 6'h08) && (x != 16'h0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_res(input logic [5:0] o, input logic [15:0] x, input logic [15:0] y);
      logic [15:0] s;
      case (o)
         6'h00: s = y;
         6'h04: s = y + x;
         6'h05: s = y - x;
         6'h06: s = 16'h0 - x;
         6'h07: return 32'(x) * 32'(y);
`ifdef ALU_SEQ_DIV_EN
         6'h08: return (x == 16'h0) ? {y, 16'hFFFF} : {16'(y % x), 16'(y / x)};
`endif
         6'h09: s = y | x;
         6'h0A: s = y ^ x;
         6'h0B: s = ~(y & x);
         6'h0C: s = ~(y | x);
         6'h0D: s = ~(y ^ x);
         6'h0E: s = ~x;
         6'h0F: s = y << x[3:0];
         6'h10: s = y >> x[3:0];
         default: return 32'h0;
      endcase
      return {16'h0, s};
   endfunction

   function automatic bit ref_err(input logic [5:0] o, input logic [15:0] x);
      case (o)
         6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B,
         6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10: return 1'b0;
`ifdef ALU_SEQ_DIV_EN
         6'h08: return (x == 16'h0);
`endif
         default: return 1'b1;
      endcase
   endfunction

   // Behavioural model advanced on each clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid  <= 1'b0;
         busy_cnt <= 0;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) begin
            m_valid <= 1'b1;
            m_res   <= m_pend;
            m_err   <= 1'b0;
         end
      end else if (in_valid && (!m_valid || out_ready)) begin
         if (is_long_div(op, a)) begin
            busy_cnt <= W;
            m_valid  <= 1'b0;
            m_pend   <= ref_res(op, a, b);
         end else begin
            m_valid <= 1'b1;
            m_res   <= ref_res(op, a, b);
            m_err   <= ref_err(op, a);
         end
      end else if (m_valid && out_ready) begin
         m_valid <= 1'b0;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 0);
         check("rst_busy", busy, 0);
         check("rst_result", result, 0);
         check("rst_err", err, 0);
      end else begin
         check("in_ready", in_ready, (busy_cnt == 0) && (!m_valid || out_ready));
         check("out_valid", out_valid, m_valid);
         check("busy", busy, m_valid || (busy_cnt != 0));
         if (m_valid) begin
            check("result", result, m_res);
            check("err", err, m_err);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] o, input logic [15:0] x, input logic [15:0] y);
      logic r;
      int n;
      op = o; a = x; b = y; in_valid = 1'b1;
      r = 1'b0; n = 0;
      while (!r && n < 40) begin
         @(negedge clk);
         r = in_ready;
         tick();
         n++;
      end
      check("issue_accept", r, 1);
      in_valid = 1'b0;
      op = 6'($urandom); a = 16'($urandom); b = 16'($urandom);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [5:0] ops [16];
      logic seen;
      ops = '{6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
              6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h3F, 6'h01};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", in_ready, 0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", in_ready, 1);
      tick();

      issue(6'h04, 16'h0001, 16'hFFFF);
      @(negedge clk);
      check("add_valid", out_valid, 1);
      check("add_result", result, 32'h00000000);
      check("add_err", err, 0);
      tick();

      issue(6'h07, 16'hFFFF, 16'hFFFF);
      @(negedge clk);
      check("mul_result", result, 32'hFFFE0001);
      tick();

      issue(6'h08, 16'h0007, 16'h0064);
`ifdef ALU_SEQ_DIV_EN
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k < 17) begin
            check("div_in_ready_low", in_ready, 0);
            check("div_no_valid", out_valid, 0);
            tick();
            in_valid = (k < 16);
            op = 6'($urandom); a = 16'($urandom); b = 16'($urandom);
         end else begin
            check("div_valid_17", out_valid, 1);
            check("div_result", result, 32'h0002000E);
            check("div_err", err, 0);
         end
      end
`else
      @(negedge clk);
      check("div_disabled_result", result, 32'h0);
      check("div_disabled_err", err, 1);
`endif
      tick();

      issue(6'h08, 16'h0000, 16'h1234);
      @(negedge clk);
      check("div0_err", err, 1);
`ifdef ALU_SEQ_DIV_EN
      check("div0_result", result, 32'h1234FFFF);
`else
      check("div0_result", result, 32'h0);
`endif
      tick();

      issue(6'h3F, 16'h0005, 16'h0006);
      @(negedge clk);
      check("illegal_err", err, 1);
      check("illegal_result", result, 32'h0);
      tick();

      out_ready = 1'b0;
      issue(6'h10, 16'h0014, 16'h8000);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("lrsh_hold_valid", out_valid, 1);
         check("lrsh_hold_result", result, 32'h00000800);
         check("lrsh_hold_ready", in_ready, 0);
         if (k < 3) tick();
      end
      tick();
      out_ready = 1'b1;
      in_valid = 1'b1; op = 6'h04; a = 16'h0002; b = 16'h0003;
      @(negedge clk);
      check("b2b_in_ready", in_ready, 1);
      check("b2b_old_result", result, 32'h00000800);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b_add_valid", out_valid, 1);
      check("b2b_add_result", result, 32'h00000005);
      tick();

`ifdef ALU_SEQ_DIV_EN
      issue(6'h08, 16'h0003, 16'h03E8);
`else
      out_ready = 1'b0;
      issue(6'h04, 16'h0001, 16'h0002);
`endif
      repeat (4) tick();
      rst_n = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("abort_in_ready", in_ready, 0);
      check("abort_busy", busy, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_release_ready", in_ready, 1);
      seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("abort_no_output", seen, 0);
      tick();

      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         op        = ops[$urandom_range(0, 15)];
         if ($urandom_range(0, 15) == 0) op = 6'($urandom);
         a         = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         b         = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
